// File: rtl/eth_switch_pkg.sv
// eth_switch_pkg: shared constants, types and helpers for the switch ingress path.
//   XGMII control codes, the CRC-32 residue seen after a good FCS,
//   the deframer FSM state type and the end-of-frame status record.
package eth_switch_pkg;

  localparam logic [7:0]  RX_START      = 8'hFB;
  localparam logic [7:0]  RX_TERM       = 8'hFD;
  localparam logic [7:0]  RX_ERR        = 8'hFE;
  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam int RX_LEN_W = 11;

  typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA} RX_STATE_t;

  typedef struct packed {
    logic [RX_LEN_W-1:0] len;
    logic                fcs_ok;
    logic                err_runt;
    logic                err_oversize;
    logic                err_code;
  } rx_status_t;

  function automatic logic [2:0] popcount4(input logic [3:0] k);
    return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
  endfunction

  // Lane 0 (earliest byte) moves to the most significant byte.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/eth_rx_deframer_if.sv
// eth_rx_deframer_if: deframer output bundle.
//   out_data/out_keep/out_valid/out_last : payload word stream
//   dst_mac/src_mac/hdr_valid            : captured addresses for MAC learning
//   frame_done/frame_len/fcs_ok/err_*     : end-of-frame status
// master = deframer, slave = downstream consumer.
interface eth_rx_deframer_if #(parameter int LEN_W = 11);
  logic [31:0]      out_data;
  logic [3:0]       out_keep;
  logic             out_valid;
  logic             out_last;
  logic [47:0]      dst_mac;
  logic [47:0]      src_mac;
  logic             hdr_valid;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             fcs_ok;
  logic             err_runt;
  logic             err_oversize;
  logic             err_code;

  modport master (output out_data, out_keep, out_valid, out_last, dst_mac, src_mac,
                  hdr_valid, frame_done, frame_len, fcs_ok, err_runt, err_oversize, err_code);
  modport slave  (input  out_data, out_keep, out_valid, out_last, dst_mac, src_mac,
                  hdr_valid, frame_done, frame_len, fcs_ok, err_runt, err_oversize, err_code);
endinterface

// File: rtl/eth_crc32_32b.sv
// eth_crc32_32b: combinational next-state for the Ethernet CRC-32 over up to
// four bytes per cycle.
//   crc_in  : current register
//   data    : bytes, lane 0 first
//   keep    : lanes to include (contiguous from lane 0)
//   crc_out : register after the kept bytes
// Bits enter LSB-first per byte (reflected CRC) but the register is kept in
// shift-left form, so a frame with a correct FCS leaves CRC32_RESIDUE.
module eth_crc32_32b
  import eth_switch_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  keep,
  output logic [31:0] crc_out
);
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < 4; b++) begin
      if (keep[b]) begin
        for (int i = 0; i < 8; i++) begin
          if (c[31] ^ data[8*b+i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
          else                     c = {c[30:0], 1'b0};
        end
      end
    end
    crc_out = c;
  end
endmodule

// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer: strips start/preamble/SFD from a 32-bit XGMII lane group
// and emits payload words, captured MACs and one status per frame.
//   clk, rst_n : core clock, async active-low reset
//   rxd, rxc   : receive lanes (lane 0 first) and per-lane control flags
//   rx_out     : eth_rx_deframer_if master (payload, header, status)
//
// state   | meaning
// RX_IDLE | waiting for FB 55 55 55 start word
// RX_PRE  | expecting 55 55 55 D5 preamble/SFD word
// RX_DATA | collecting payload until terminate or a new start
module eth_rx_deframer
  import eth_switch_pkg::*;
#(
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64,
  parameter int LEN_W     = RX_LEN_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rxd,
  input  logic [3:0]  rxc,
  eth_rx_deframer_if.master rx_out
);
  RX_STATE_t state, state_nxt;

  // Stage register: holds one word until the next cycle shows whether it is final.
  logic [31:0] stg_data, stg_data_nxt;
  logic [3:0]  stg_keep, stg_keep_nxt;
  logic        stg_valid, stg_valid_nxt;
  logic        stg_err, stg_err_nxt;

  logic [LEN_W-1:0] acc_len;
  logic [31:0]      acc_crc, crc_nxt, mac_sh0, mac_sh1;
  logic             acc_err, err_nxt;

  logic       emit, frame_end, abort, term_any, start_word, pre_ok, lane0_start, hdr_hit;
  logic [3:0] term_hit, low_mask, eff_keep;
  logic [1:0] term_k;
  logic [LEN_W:0]   len_wide;
  logic [LEN_W-1:0] len_sum;
  rx_status_t st_nxt, st_q;

  logic [31:0] out_data_q;
  logic [3:0]  out_keep_q;
  logic        out_valid_q, out_last_q, hdr_valid_q, frame_done_q;
  logic [47:0] dst_q, src_q;

  always_comb begin
    term_hit = 4'h0;
    for (int k = 0; k < 4; k++) term_hit[k] = rxc[k] && (rxd[8*k +: 8] == RX_TERM);
  end

  // Lowest terminate lane wins; low_mask covers the data lanes before it.
  always_comb begin
    term_k   = 2'd0;
    low_mask = 4'hF;
    for (int k = 3; k >= 0; k--) begin
      if (term_hit[k]) begin
        term_k   = 2'(k);
        low_mask = 4'((1 << k) - 1);
      end
    end
  end

  assign term_any    = |term_hit;
  assign lane0_start = rxc[0] && (rxd[7:0] == RX_START);
  assign start_word  = (rxc == 4'b0001) && (rxd == {PREAMBLE, PREAMBLE, PREAMBLE, RX_START});
  assign pre_ok      = (rxc == 4'b0000) && (rxd == {SFD, PREAMBLE, PREAMBLE, PREAMBLE});

  always_comb begin
    state_nxt     = state;
    stg_data_nxt  = stg_data;
    stg_keep_nxt  = stg_keep;
    stg_valid_nxt = stg_valid;
    stg_err_nxt   = stg_err;
    emit          = 1'b0;
    frame_end     = 1'b0;
    abort         = 1'b0;
    unique case (state)
      RX_IDLE, RX_PRE: begin
        // A partial final word left by a terminate in lane 1-3 drains here.
        if (stg_valid) begin
          emit          = 1'b1;
          frame_end     = 1'b1;
          stg_valid_nxt = 1'b0;
        end
        if (state == RX_IDLE) begin
          if (start_word) state_nxt = RX_PRE;
        end else begin
          state_nxt = pre_ok ? RX_DATA : RX_IDLE;
        end
      end
      RX_DATA: begin
        emit = stg_valid;
        if (lane0_start) begin
          state_nxt     = RX_PRE;
          frame_end     = 1'b1;
          abort         = 1'b1;
          stg_valid_nxt = 1'b0;
        end else if (term_any && term_k == 2'd0) begin
          state_nxt     = RX_IDLE;
          frame_end     = 1'b1;
          stg_valid_nxt = 1'b0;
        end else begin
          stg_data_nxt  = rxd;
          stg_keep_nxt  = low_mask;
          stg_valid_nxt = 1'b1;
          stg_err_nxt   = |(rxc & low_mask);
          if (term_any) state_nxt = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign eff_keep = emit ? stg_keep : 4'h0;
  assign len_wide = {1'b0, acc_len} + (LEN_W+1)'(popcount4(eff_keep));
  assign len_sum  = len_wide[LEN_W] ? '1 : len_wide[LEN_W-1:0];
  assign err_nxt  = acc_err | (emit & stg_err) | abort;
  assign hdr_hit  = emit && stg_keep[3] && (acc_len == LEN_W'(8));

  eth_crc32_32b u_crc (
    .crc_in  (acc_crc),
    .data    (stg_data),
    .keep    (eff_keep),
    .crc_out (crc_nxt)
  );

  always_comb begin
    st_nxt              = '0;
    st_nxt.len          = RX_LEN_W'(len_sum);
    st_nxt.fcs_ok       = (crc_nxt == CRC32_RESIDUE);
    st_nxt.err_runt     = int'(len_sum) < MIN_FRAME;
    st_nxt.err_oversize = int'(len_sum) > MAX_FRAME;
    st_nxt.err_code     = err_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      stg_data  <= '0;
      stg_keep  <= '0;
      stg_valid <= 1'b0;
      stg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      stg_data  <= stg_data_nxt;
      stg_keep  <= stg_keep_nxt;
      stg_valid <= stg_valid_nxt;
      stg_err   <= stg_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_len <= '0;
      acc_crc <= 32'hFFFF_FFFF;
      acc_err <= 1'b0;
      mac_sh0 <= '0;
      mac_sh1 <= '0;
    end else begin
      if (frame_end || state_nxt == RX_PRE) begin
        acc_len <= '0;
        acc_crc <= 32'hFFFF_FFFF;
        acc_err <= 1'b0;
      end else if (emit) begin
        acc_len <= len_sum;
        acc_crc <= crc_nxt;
        acc_err <= err_nxt;
      end
      if (emit && acc_len == LEN_W'(0)) mac_sh0 <= bswap32(stg_data);
      if (emit && acc_len == LEN_W'(4)) mac_sh1 <= bswap32(stg_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      hdr_valid_q  <= 1'b0;
      st_q         <= '0;
      dst_q        <= '0;
      src_q        <= '0;
    end else begin
      out_data_q   <= emit ? stg_data : '0;
      out_keep_q   <= eff_keep;
      out_valid_q  <= emit;
      out_last_q   <= emit && frame_end;
      frame_done_q <= frame_end;
      hdr_valid_q  <= hdr_hit;
      if (frame_end) st_q <= st_nxt;
      if (hdr_hit) begin
        dst_q <= {mac_sh0, mac_sh1[31:16]};
        src_q <= {mac_sh1[15:0], bswap32(stg_data)};
      end
    end
  end

  assign rx_out.out_data     = out_data_q;
  assign rx_out.out_keep     = out_keep_q;
  assign rx_out.out_valid    = out_valid_q;
  assign rx_out.out_last     = out_last_q;
  assign rx_out.dst_mac      = dst_q;
  assign rx_out.src_mac      = src_q;
  assign rx_out.hdr_valid    = hdr_valid_q;
  assign rx_out.frame_done   = frame_done_q;
  assign rx_out.frame_len    = LEN_W'(st_q.len);
  assign rx_out.fcs_ok       = st_q.fcs_ok;
  assign rx_out.err_runt     = st_q.err_runt;
  assign rx_out.err_oversize = st_q.err_oversize;
  assign rx_out.err_code     = st_q.err_code;
endmodule

// File: tb/tb_eth_rx_deframer.sv
// tb_eth_rx_deframer: scoreboard bench for eth_rx_deframer.
// Frames are built byte-wise with a standard Ethernet FCS; expected words,
// headers and status are queued when a frame is driven and popped when the
// DUT produces them.
module tb_eth_rx_deframer;
  import eth_switch_pkg::*;

  localparam int LEN_W = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rxd = 32'h0707_0707;
  logic [3:0]  rxc = 4'hF;

  always #5 clk = ~clk;

  eth_rx_deframer_if #(.LEN_W(LEN_W)) rx_if ();

  eth_rx_deframer #(.MAX_FRAME(1518), .MIN_FRAME(64), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxd    (rxd),
    .rxc    (rxc),
    .rx_out (rx_if)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             fcs_ok;
    logic             runt;
    logic             over;
    logic             code;
  } stat_t;

  word_t       wq[$];
  stat_t       sq[$];
  logic [95:0] hq[$];
  logic [7:0]  fb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          discard = 1'b0;

  word_t       m_w;
  stat_t       m_s;
  logic [95:0] m_h;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] keep_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // Reflected CRC-32 (shift-right form) over the first n bytes of fb.
  function automatic logic [31:0] crc_fb(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_frame(input int n, input logic [47:0] dst, input logic [47:0] src, input int seed);
    logic [31:0] f;
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(src[47-8*i -: 8]);
    for (int i = 12; i < n - 4; i++) fb.push_back(8'((i * 7 + seed) & 255));
    f = ~crc_fb(fb.size());
    for (int i = 0; i < 4; i++) fb.push_back(f[8*i +: 8]);
  endtask

  task automatic expect_frame(input logic code);
    int    n, nw;
    stat_t s;
    logic [95:0] h;
    n  = fb.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word_t e;
      e = '0;
      for (int k = 0; k < 4; k++) begin
        if (4*w + k < n) begin
          e.data[8*k +: 8] = fb[4*w + k];
          e.keep[k] = 1'b1;
        end
      end
      e.last = (w == nw - 1);
      wq.push_back(e);
    end
    s.len    = LEN_W'(n);
    s.fcs_ok = (crc_fb(n) == 32'hDEBB_20E3);
    s.runt   = (n < 64);
    s.over   = (n > 1518);
    s.code   = code;
    sq.push_back(s);
    if (n >= 12) begin
      h = '0;
      for (int i = 0; i < 12; i++) h[95-8*i -: 8] = fb[i];
      hq.push_back(h);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] c);
    @(posedge clk);
    #1;
    rxd = d;
    rxc = c;
  endtask

  // cut >= 0 stops after that many data words with no terminate.
  task automatic send_frame(input logic [7:0] sfd, input int ctrl_pos, input int cut, input int gap);
    int n, nw, r, idx;
    logic [31:0] d;
    logic [3:0]  c;
    n  = fb.size();
    nw = n / 4;
    r  = n % 4;
    drive({PREAMBLE, PREAMBLE, PREAMBLE, RX_START}, 4'b0001);
    drive({sfd, PREAMBLE, PREAMBLE, PREAMBLE}, 4'b0000);
    for (int w = 0; w < nw; w++) begin
      if (cut >= 0 && w == cut) return;
      for (int k = 0; k < 4; k++) begin
        d[8*k +: 8] = fb[4*w + k];
        c[k] = (4*w + k == ctrl_pos);
      end
      drive(d, c);
    end
    for (int k = 0; k < 4; k++) begin
      idx = 4*nw + k;
      if (k < r) begin
        d[8*k +: 8] = fb[idx];
        c[k] = (idx == ctrl_pos);
      end else if (k == r) begin
        d[8*k +: 8] = RX_TERM;
        c[k] = 1'b1;
      end else begin
        d[8*k +: 8] = 8'h07;
        c[k] = 1'b1;
      end
    end
    drive(d, c);
    repeat (gap) drive(32'h0707_0707, 4'hF);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs",
            {rx_if.out_valid, rx_if.out_last, rx_if.frame_done, rx_if.hdr_valid,
             rx_if.out_data, rx_if.dst_mac, rx_if.src_mac},
            '0);
    end else begin
      if (rx_if.out_valid && !discard) begin
        if (wq.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          m_w = wq.pop_front();
          check("out_data", rx_if.out_data & keep_mask(rx_if.out_keep), m_w.data);
          check("out_keep", rx_if.out_keep, m_w.keep);
          check("out_last", rx_if.out_last, m_w.last);
        end
      end
      if (rx_if.frame_done) begin
        if (discard) begin
          check("cut_frame_done", 1, 0);
        end else if (sq.size() == 0) begin
          check("extra_status", 1, 0);
        end else begin
          m_s = sq.pop_front();
          check("frame_len", rx_if.frame_len, m_s.len);
          check("fcs_ok", rx_if.fcs_ok, m_s.fcs_ok);
          check("err_runt", rx_if.err_runt, m_s.runt);
          check("err_oversize", rx_if.err_oversize, m_s.over);
          check("err_code", rx_if.err_code, m_s.code);
          check("done_with_last", rx_if.out_last, 1);
        end
      end
      if (rx_if.hdr_valid && !discard) begin
        if (hq.size() == 0) begin
          check("extra_hdr", 1, 0);
        end else begin
          m_h = hq.pop_front();
          check("macs", {rx_if.dst_mac, rx_if.src_mac}, m_h);
        end
      end
    end
  end

  localparam logic [47:0] MAC_A = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_B = 48'h02_00_00_00_00_02;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) drive(32'h0707_0707, 4'hF);

    // 64 bytes, terminate in lane 0
    build_frame(64, MAC_A, MAC_B, 1);
    expect_frame(1'b0);
    send_frame(SFD, -1, -1, 4);

    // 65 bytes, terminate in lane 1
    build_frame(65, MAC_B, MAC_A, 2);
    expect_frame(1'b0);
    send_frame(SFD, -1, -1, 4);

    // flipped payload bit
    build_frame(64, MAC_A, MAC_B, 1);
    fb[20] = fb[20] ^ 8'h08;
    expect_frame(1'b0);
    send_frame(SFD, -1, -1, 4);

    // error character mid-frame
    build_frame(64, MAC_A, MAC_B, 3);
    fb[30] = RX_ERR;
    expect_frame(1'b1);
    send_frame(SFD, 30, -1, 4);

    // runt and oversize
    build_frame(40, MAC_A, MAC_B, 4);
    expect_frame(1'b0);
    send_frame(SFD, -1, -1, 4);
    build_frame(1522, MAC_B, MAC_A, 9);
    expect_frame(1'b0);
    send_frame(SFD, -1, -1, 4);

    // back-to-back frames, then a bad SFD frame
    build_frame(65, MAC_A, MAC_B, 5);
    expect_frame(1'b0);
    send_frame(SFD, -1, -1, 0);
    build_frame(64, MAC_B, MAC_A, 6);
    expect_frame(1'b0);
    send_frame(SFD, -1, -1, 4);
    build_frame(64, MAC_A, MAC_A, 7);
    send_frame(8'hD4, -1, -1, 4);

    // reset in the middle of a payload
    build_frame(64, MAC_A, MAC_B, 8);
    discard = 1'b1;
    send_frame(SFD, -1, 5, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rxd   = 32'h0707_0707;
    rxc   = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    discard = 1'b0;
    repeat (2) drive(32'h0707_0707, 4'hF);
    build_frame(68, MAC_B, MAC_B, 10);
    expect_frame(1'b0);
    send_frame(SFD, -1, -1, 4);

    for (int i = 0; i < 200 && (wq.size() + sq.size() + hq.size()) > 0; i++) @(posedge clk);
    check("words_left", wq.size(), 0);
    check("status_left", sq.size(), 0);
    check("hdr_left", hq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
